// File: rtl/match_rom_id_sender_if.sv
// ============================================================================
// Module   : match_rom_id_sender_if
// Desc     : Handshake and 1-Wire bus signals of the Match-ROM ID sender.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface match_rom_id_sender_if #(
  parameter int N_BITS = 64
);
  logic              en_match_id;
  logic [N_BITS-1:0] rom_id;
  logic              bus;
  logic              master_pull_low;
  logic              busy;
  logic              done_sending_id;
  logic              crc_ok;
  logic              bus_err;

  modport master (
    output en_match_id, rom_id, bus,
    input  master_pull_low, busy, done_sending_id, crc_ok, bus_err
  );

  modport slave (
    input  en_match_id, rom_id, bus,
    output master_pull_low, busy, done_sending_id, crc_ok, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/match_rom_id_sender.sv
// ============================================================================
// Module   : match_rom_id_sender
// Desc     : Serialises a 64-bit 1-Wire ROM ID LSB first with write-0/write-1
//            slots, checks its Dallas CRC8 and flags a stuck-low bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_rom_id_sender #(
  parameter int T_SLOT = 60,
  parameter int T_LOW1 = 6,
  parameter int T_REC  = 11,
  parameter int N_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  match_rom_id_sender_if.slave  ow
);

  localparam int c_bit_ticks = T_SLOT + T_REC;
  localparam int c_tick_w    = $clog2(c_bit_ticks);
  localparam int c_idx_w     = $clog2(N_BITS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SLOT_LOW = 3'd1,
    S_SLOT_REL = 3'd2,
    S_RECOVER  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t              state_q,    state_d;
  logic [N_BITS-1:0]   shift_q,    shift_d;
  logic [7:0]          crc_byte_q, crc_byte_d;
  logic [c_idx_w-1:0]  idx_q,      idx_d;
  logic [c_tick_w-1:0] tick_q,     tick_d;
  logic [7:0]          crc_q,      crc_d;
  logic                crc_ok_q,   crc_ok_d;
  logic                bus_err_q,  bus_err_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;

  logic                fb;
  logic [7:0]          crc_next;
  logic                active;

  // Reflected CRC8 step over the bit currently on the wire.
  always_comb begin
    fb       = crc_q[0] ^ shift_q[0];
    crc_next = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
    active   = (state_q == S_SLOT_LOW) || (state_q == S_SLOT_REL) ||
               (state_q == S_RECOVER);
  end

  // Next-state logic: slot sequencing, CRC accumulation, completion and abort.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    crc_byte_d = crc_byte_q;
    idx_d      = idx_q;
    tick_d     = tick_q;
    crc_d      = crc_q;
    crc_ok_d   = crc_ok_q;
    bus_err_d  = bus_err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ow.en_match_id) begin
          shift_d    = ow.rom_id;
          crc_byte_d = ow.rom_id[N_BITS-1 -: 8];
          idx_d      = '0;
          tick_d     = '0;
          crc_d      = '0;
          crc_ok_d   = 1'b0;
          bus_err_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SLOT_LOW;
        end
      end
      S_SLOT_LOW: begin
        tick_d = tick_q + 1'b1;
        // A write-1 releases early; a write-0 holds low for the whole slot.
        if (shift_q[0] && (tick_q == c_tick_w'(T_LOW1 - 1))) begin
          state_d = S_SLOT_REL;
        end else if (!shift_q[0] && (tick_q == c_tick_w'(T_SLOT - 1))) begin
          state_d = S_RECOVER;
        end
      end
      S_SLOT_REL: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == c_tick_w'(T_SLOT - 1)) begin
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == c_tick_w'(c_bit_ticks - 1)) begin
          // The line must have recovered high by the end of the window.
          if (!ow.bus) begin
            bus_err_d = 1'b1;
          end
          if (idx_q < c_idx_w'(N_BITS - 8)) begin
            crc_d = crc_next;
          end
          if (idx_q == c_idx_w'(N_BITS - 1)) begin
            done_d   = 1'b1;
            crc_ok_d = (crc_q == crc_byte_q);
            busy_d   = 1'b0;
            state_d  = S_DONE;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            tick_d  = '0;
            state_d = S_SLOT_LOW;
          end
        end
      end
      S_DONE: begin
        if (!ow.en_match_id) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping the enable mid-transfer aborts without a done pulse.
    if (active && !ow.en_match_id) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      crc_ok_d  = 1'b0;
      done_d    = 1'b0;
      bus_err_d = bus_err_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      crc_byte_q <= '0;
      idx_q      <= '0;
      tick_q     <= '0;
      crc_q      <= '0;
      crc_ok_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      crc_byte_q <= crc_byte_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      crc_q      <= crc_d;
      crc_ok_q   <= crc_ok_d;
      bus_err_q  <= bus_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ow.master_pull_low = (state_q == S_SLOT_LOW);
  assign ow.busy            = busy_q;
  assign ow.done_sending_id = done_q;
  assign ow.crc_ok          = crc_ok_q;
  assign ow.bus_err         = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_match_rom_id_sender.sv
// ============================================================================
// Module   : tb_match_rom_id_sender
// Desc     : Self-checking bench for match_rom_id_sender.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_match_rom_id_sender;

  localparam int c_bit = 71;

  logic clk = 1'b0;
  logic rst_n;
  logic force_low;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  match_rom_id_sender_if ow_if ();

  // Open-drain line: released high unless the master or a fault pulls it low.
  assign ow_if.bus = ~ow_if.master_pull_low & ~force_low;

  match_rom_id_sender dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ow    (ow_if)
  );

  function automatic logic crc_model(input logic [63:0] id);
    logic [7:0] c;
    logic       f;
    c = 8'h00;
    for (int i = 0; i < 56; i++) begin
      f = c[0] ^ id[i];
      c = (c >> 1) ^ (f ? 8'h8C : 8'h00);
    end
    return c == id[63:56];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ow_if.en_match_id = 1'b0;
    ow_if.rom_id = '0;
    force_low = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ow_if.master_pull_low, ow_if.busy, ow_if.done_sending_id,
         ow_if.crc_ok, ow_if.bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {ow_if.master_pull_low, ow_if.busy, ow_if.done_sending_id,
                ow_if.crc_ok, ow_if.bus_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full transfer: expected low-pulse lengths are queued up front and popped
  // as each low pulse on the line completes.
  task automatic run_transfer(input logic [63:0] id, input int err_bit,
                              input bit hold_after);
    logic prev;
    int   run;
    int   nbit;
    int   exp_len;
    bit   seen_done;
    bit   extra;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(id[i] ? 6 : 60);
    @(negedge clk);
    ow_if.rom_id = id;
    ow_if.en_match_id = 1'b1;
    prev = 1'b0; run = 0; nbit = 0; seen_done = 1'b0;
    for (int k = 0; k < 6000 && !seen_done; k++) begin
      @(negedge clk);
      if (k == 1) ow_if.rom_id = ~id;
      if (k == 0) begin
        checks++;
        if (ow_if.busy !== 1'b1) begin
          errors++; $display("FAIL busy_start got %b want 1", ow_if.busy);
        end
      end
      if (err_bit >= 0) begin
        if (k == err_bit * c_bit + 60) force_low = 1'b1;
        if (k == err_bit * c_bit + 70) begin
          checks++;
          if (ow_if.bus_err !== 1'b0) begin
            errors++; $display("FAIL bus_err_early got %b want 0", ow_if.bus_err);
          end
        end
        if (k == err_bit * c_bit + 71) begin
          force_low = 1'b0;
          checks++;
          if (ow_if.bus_err !== 1'b1) begin
            errors++; $display("FAIL bus_err_set got %b want 1", ow_if.bus_err);
          end
        end
      end
      if (ow_if.master_pull_low && !prev) begin
        checks++;
        if (k !== nbit * c_bit) begin
          errors++; $display("FAIL low_start bit %0d got cycle %0d want %0d", nbit, k, nbit * c_bit);
        end
        run = 1;
      end else if (ow_if.master_pull_low) begin
        run++;
      end else if (prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_pulse got len %0d want none", run);
        end else begin
          exp_len = exp_q.pop_front();
          if (run !== exp_len) begin
            errors++; $display("FAIL low_len bit %0d got %0d want %0d", nbit, run, exp_len);
          end
        end
        nbit++;
      end
      prev = ow_if.master_pull_low;
      if (ow_if.done_sending_id) begin
        seen_done = 1'b1;
        checks++;
        if (k !== 64 * c_bit) begin
          errors++; $display("FAIL done_cycle got %0d want %0d", k, 64 * c_bit);
        end
        checks++;
        if (ow_if.crc_ok !== crc_model(id)) begin
          errors++; $display("FAIL crc_ok got %b want %b", ow_if.crc_ok, crc_model(id));
        end
        checks++;
        if (ow_if.bus_err !== (err_bit >= 0)) begin
          errors++; $display("FAIL bus_err_done got %b want %b", ow_if.bus_err, err_bit >= 0);
        end
        checks++;
        if (ow_if.busy !== 1'b0 || exp_q.size() != 0) begin
          errors++; $display("FAIL end_state got busy %b left %0d want busy 0 left 0", ow_if.busy, exp_q.size());
        end
      end
    end
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL done_timeout got none want pulse");
    end
    @(negedge clk);
    checks++;
    if (ow_if.done_sending_id !== 1'b0) begin
      errors++; $display("FAIL done_width got %b want 0", ow_if.done_sending_id);
    end
    if (hold_after) begin
      extra = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (ow_if.done_sending_id || ow_if.master_pull_low || ow_if.busy) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
        errors++; $display("FAIL no_restart got %b want 0", extra);
      end
      checks++;
      if (ow_if.bus_err !== 1'b1) begin
        errors++; $display("FAIL bus_err_hold got %b want 1", ow_if.bus_err);
      end
    end
    ow_if.en_match_id = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    bit extra;
    @(negedge clk);
    ow_if.rom_id = 64'hA2000000_01B81C02;
    ow_if.en_match_id = 1'b1;
    for (int k = 0; k <= 10 * c_bit + 3; k++) @(negedge clk);
    checks++;
    if (ow_if.master_pull_low !== 1'b1) begin
      errors++; $display("FAIL abort_pre got %b want 1", ow_if.master_pull_low);
    end
    ow_if.en_match_id = 1'b0;
    @(negedge clk);
    checks++;
    if ({ow_if.master_pull_low, ow_if.busy, ow_if.crc_ok} !== 3'b000) begin
      errors++; $display("FAIL abort_release got %b want 000",
                         {ow_if.master_pull_low, ow_if.busy, ow_if.crc_ok});
    end
    extra = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (ow_if.done_sending_id || ow_if.master_pull_low) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++; $display("FAIL abort_quiet got %b want 0", extra);
    end
    run_transfer(64'hA2000000_01B81C02, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ow_if.rom_id = 64'h0;
    ow_if.en_match_id = 1'b1;
    for (int k = 0; k <= 3 * c_bit + 2; k++) begin
      @(negedge clk);
      if (k == c_bit + 60) force_low = 1'b1;
      if (k == c_bit + 71) force_low = 1'b0;
    end
    checks++;
    if (ow_if.bus_err !== 1'b1 || ow_if.busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset got err %b busy %b want 1 1", ow_if.bus_err, ow_if.busy);
    end
    rst_n = 1'b0;
    ow_if.en_match_id = 1'b0;
    @(negedge clk);
    checks++;
    if ({ow_if.master_pull_low, ow_if.busy, ow_if.done_sending_id,
         ow_if.crc_ok, ow_if.bus_err} !== 5'b0) begin
      errors++; $display("FAIL mid_reset got %b want 00000",
                         {ow_if.master_pull_low, ow_if.busy, ow_if.done_sending_id,
                          ow_if.crc_ok, ow_if.bus_err});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_transfer(64'hA2000000_01B81C02, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    run_transfer(64'h0, -1, 1'b0);
    run_transfer(64'hA2000000_01B81C02, -1, 1'b0);
    run_transfer(64'hA3000000_01B81C02, -1, 1'b0);
    test_abort();
    run_transfer(64'hA2000000_01B81C02, 5, 1'b1);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
